// File: rtl/spike_link_rx.sv
// Receive side of the FPGA-FPGA spike link: synchronise, de-glitch and edge-detect each
// spike line, re-time spikes onto neuron_tick, and count deliveries per sim step.
module spike_link_rx #(
  parameter int N        = 14,
  parameter int MIN_HIGH = 2,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               neuron_tick,
  input  logic               sim_tick,
  input  logic [N-1:0]       spikein,
  output logic [N-1:0]       each_spike,
  output logic [N*CNT_W-1:0] spike_count,
  output logic [N-1:0]       collision
);

  localparam int            HW         = 4;
  localparam logic [HW-1:0] MIN_HIGH_C = HW'(MIN_HIGH);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  logic [N-1:0]     s1_q, s1_d, s2_q, s2_d;
  logic [N-1:0]     q_q, q_d, qd_q, qd_d;
  logic [N-1:0]     each_q, each_d, coll_q, coll_d;
  logic [N-1:0]     ev, deliver;
  logic [HW-1:0]    hcnt_q [N];
  logic [HW-1:0]    hcnt_d [N];
  state_t           state_q [N];
  state_t           state_d [N];
  logic [CNT_W-1:0] win_q [N];
  logic [CNT_W-1:0] win_d [N];
  logic [CNT_W-1:0] cnt_q [N];
  logic [CNT_W-1:0] cnt_d [N];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    if (inc && !(&v)) return v + CNT_W'(1);
    return v;
  endfunction

  assign ev = q_q & ~qd_q;

  always_comb begin
    s1_d    = spikein;
    s2_d    = s1_q;
    qd_d    = q_q;
    q_d     = '0;
    coll_d  = coll_q;
    deliver = '0;
    for (int i = 0; i < N; i++) begin
      hcnt_d[i]  = '0;
      state_d[i] = state_q[i];
      win_d[i]   = win_q[i];
      cnt_d[i]   = cnt_q[i];

      if (s2_q[i]) begin
        hcnt_d[i] = (hcnt_q[i] == MIN_HIGH_C) ? hcnt_q[i] : hcnt_q[i] + HW'(1);
      end
      q_d[i] = (hcnt_q[i] == MIN_HIGH_C);

      // A tick always drains the pending spike; a new edge on that same tick takes its place.
      case (state_q[i])
        IDLE: begin
          if (ev[i]) begin
            if (neuron_tick) deliver[i] = 1'b1;
            else             state_d[i] = PEND;
          end
        end
        PEND: begin
          if (neuron_tick) begin
            deliver[i] = 1'b1;
            state_d[i] = ev[i] ? PEND : IDLE;
          end else if (ev[i]) begin
            coll_d[i] = 1'b1;
          end
        end
        default: state_d[i] = IDLE;
      endcase

      if (sim_tick) begin
        cnt_d[i] = sat_inc(win_q[i], deliver[i]);
        win_d[i] = '0;
      end else begin
        win_d[i] = sat_inc(win_q[i], deliver[i]);
      end
    end
    each_d = deliver;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      q_q    <= '0;
      qd_q   <= '0;
      each_q <= '0;
      coll_q <= '0;
      for (int i = 0; i < N; i++) begin
        hcnt_q[i]  <= '0;
        state_q[i] <= IDLE;
        win_q[i]   <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      q_q    <= q_d;
      qd_q   <= qd_d;
      each_q <= each_d;
      coll_q <= coll_d;
      for (int i = 0; i < N; i++) begin
        hcnt_q[i]  <= hcnt_d[i];
        state_q[i] <= state_d[i];
        win_q[i]   <= win_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign each_spike = each_q;
  assign collision  = coll_q;

  for (genvar g = 0; g < N; g++) begin : g_count
    assign spike_count[g*CNT_W +: CNT_W] = cnt_q[g];
  end

endmodule
